// File: rtl/sdpram16_fifo_ctrl.sv
// 16-deep FIFO controller for the SDPRAMB 16x2 distributed-RAM slice.
// Drives the slice write/read ports and registers the asynchronous read output.
module sdpram16_fifo_ctrl #(
  parameter int DW        = 2,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          FLUSH,
  input  logic          WR_EN,
  input  logic [DW-1:0] WR_DATA,
  input  logic          RD_EN,
  output logic [DW-1:0] RD_DATA,
  output logic          RD_VALID,
  output logic          FULL,
  output logic          EMPTY,
  output logic          ALMOST_FULL,
  output logic          ALMOST_EMPTY,
  output logic [4:0]    COUNT,
  output logic          OVF,
  output logic          UDF,
  output logic [3:0]    RAM_WAD,
  output logic [DW-1:0] RAM_WD,
  output logic          RAM_WRE,
  output logic [3:0]    RAM_RAD,
  input  logic [DW-1:0] RAM_F
);

  localparam logic [4:0] AF_LVL    = 5'(AF_THRESH);
  localparam logic [4:0] AE_LVL    = 5'(AE_THRESH);
  localparam logic [4:0] DEPTH     = 5'd16;

  logic [3:0]    wr_ptr_r;
  logic [3:0]    rd_ptr_r;
  logic [4:0]    count_r;
  logic [DW-1:0] rd_data_r;
  logic          rd_valid_r;
  logic          ovf_r;
  logic          udf_r;

  logic          full_s;
  logic          empty_s;
  logic          wr_acc_s;
  logic          rd_acc_s;
  logic [4:0]    count_nxt_s;

  // Occupancy flags and accept terms decoded from registered state only.
  always_comb begin
    full_s   = (count_r == DEPTH);
    empty_s  = (count_r == 5'd0);
    wr_acc_s = WR_EN & ~full_s & ~FLUSH;
    rd_acc_s = RD_EN & ~empty_s & ~FLUSH;
  end

  // Next occupancy: simultaneous accepted write and read cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + 5'd1;
      2'b01:   count_nxt_s = count_r - 5'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_r <= 4'd0;
      rd_ptr_r <= 4'd0;
      count_r  <= 5'd0;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else if (FLUSH) begin
      wr_ptr_r <= 4'd0;
      rd_ptr_r <= 4'd0;
      count_r  <= 5'd0;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + 4'd1;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + 4'd1;
      end
      count_r <= count_nxt_s;
      ovf_r   <= ovf_r | (WR_EN & full_s);
      udf_r   <= udf_r | (RD_EN & empty_s);
    end
  end

  // Output register replacing the slice Q flop; data survives FLUSH.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rd_data_r <= RAM_F;
      end
    end
  end

  // Slice drive and status outputs; write enable is held off during reset.
  always_comb begin
    RAM_WRE      = wr_acc_s & RSTN;
    RAM_WAD      = wr_ptr_r;
    RAM_WD       = WR_DATA;
    RAM_RAD      = rd_ptr_r;
    RD_DATA      = rd_data_r;
    RD_VALID     = rd_valid_r;
    COUNT        = count_r;
    FULL         = full_s;
    EMPTY        = empty_s;
    ALMOST_FULL  = (count_r >= AF_LVL);
    ALMOST_EMPTY = (count_r <= AE_LVL);
    OVF          = ovf_r;
    UDF          = udf_r;
  end

endmodule

// File: tb/tb_sdpram16_fifo_ctrl.sv
// Scoreboard bench for sdpram16_fifo_ctrl with a behavioural SDPRAMB slice.
module tb_sdpram16_fifo_ctrl;

  localparam int DW = 4;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          FLUSH = 1'b0;
  logic          WR_EN = 1'b0;
  logic [DW-1:0] WR_DATA = '0;
  logic          RD_EN = 1'b0;
  logic [DW-1:0] RD_DATA;
  logic          RD_VALID;
  logic          FULL;
  logic          EMPTY;
  logic          ALMOST_FULL;
  logic          ALMOST_EMPTY;
  logic [4:0]    COUNT;
  logic          OVF;
  logic          UDF;
  logic [3:0]    RAM_WAD;
  logic [DW-1:0] RAM_WD;
  logic          RAM_WRE;
  logic [3:0]    RAM_RAD;
  logic [DW-1:0] RAM_F;

  sdpram16_fifo_ctrl #(.DW(DW), .AF_THRESH(12), .AE_THRESH(2)) dut (
    .CLK(CLK), .RSTN(RSTN), .FLUSH(FLUSH), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .FULL(FULL),
    .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
    .COUNT(COUNT), .OVF(OVF), .UDF(UDF), .RAM_WAD(RAM_WAD), .RAM_WD(RAM_WD),
    .RAM_WRE(RAM_WRE), .RAM_RAD(RAM_RAD), .RAM_F(RAM_F)
  );

  always #5 CLK = ~CLK;

  // Behavioural distributed-RAM slice: synchronous write, asynchronous read.
  logic [DW-1:0] mem [16];
  always @(posedge CLK) if (RAM_WRE) mem[RAM_WAD] <= RAM_WD;
  assign RAM_F = mem[RAM_RAD];

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mq [$];
  logic [DW-1:0] exp_q [$];
  int            m_wptr = 0;
  int            m_rptr = 0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic          m_vld = 1'b0;
  logic [DW-1:0] m_last = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every RD_VALID pulse must match the oldest expected word.
  always @(negedge CLK) begin
    if (RSTN && RD_VALID) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got RD_VALID with data %0h, expected no pop", RD_DATA);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (RD_DATA !== e) begin
          failures++;
          $display("FAIL sb_data: got %0h expected %0h", RD_DATA, e);
        end
      end
    end
  end

  // One clock of stimulus with model update and post-edge status checks.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    logic wacc, racc, was_full, was_empty;
    WR_EN = w; WR_DATA = d; RD_EN = r; FLUSH = f;
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    wacc = w && !was_full && !f;
    racc = r && !was_empty && !f;
    #1;
    chk("ram_wre", RAM_WRE, wacc);
    chk("ram_wd", RAM_WD, d);
    chk("ram_wad", RAM_WAD, m_wptr);
    chk("ram_rad", RAM_RAD, m_rptr);
    if (f) begin
      mq.delete();
      m_wptr = 0; m_rptr = 0; m_ovf = 1'b0; m_udf = 1'b0; m_vld = 1'b0;
    end else begin
      if (w && was_full) m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
      m_vld = racc;
      if (racc) begin
        m_last = mq.pop_front();
        exp_q.push_back(m_last);
        m_rptr = (m_rptr + 1) % 16;
      end
      if (wacc) begin
        mq.push_back(d);
        m_wptr = (m_wptr + 1) % 16;
      end
    end
    @(posedge CLK); #1;
    chk("count", COUNT, mq.size());
    chk("full", FULL, mq.size() == 16);
    chk("empty", EMPTY, mq.size() == 0);
    chk("almost_full", ALMOST_FULL, mq.size() >= 12);
    chk("almost_empty", ALMOST_EMPTY, mq.size() <= 2);
    chk("ovf", OVF, m_ovf);
    chk("udf", UDF, m_udf);
    chk("rd_valid", RD_VALID, m_vld);
    chk("rd_data", RD_DATA, m_last);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_count"}, COUNT, 0);
    chk({tag, "_rd_data"}, RD_DATA, 0);
    chk({tag, "_rd_valid"}, RD_VALID, 0);
    chk({tag, "_ovf"}, OVF, 0);
    chk({tag, "_udf"}, UDF, 0);
    chk({tag, "_empty"}, EMPTY, 1);
    chk({tag, "_full"}, FULL, 0);
    chk({tag, "_ae"}, ALMOST_EMPTY, 1);
    chk({tag, "_af"}, ALMOST_FULL, 0);
    chk({tag, "_wre"}, RAM_WRE, 0);
    chk({tag, "_wad"}, RAM_WAD, 0);
    chk({tag, "_rad"}, RAM_RAD, 0);
  endtask

  task automatic model_reset();
    mq.delete(); exp_q.delete();
    m_wptr = 0; m_rptr = 0; m_ovf = 1'b0; m_udf = 1'b0; m_vld = 1'b0; m_last = '0;
  endtask

  initial begin
    // Reset with a write request pending: RAM_WRE must stay low.
    WR_EN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    reset_vals("rst");
    WR_EN = 1'b0;
    RSTN = 1'b1;

    // Fill 0..15, then a 17th write sets OVF.
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    chk("fill_count16", COUNT, 16);
    step(1'b1, 4'hA, 1'b0, 1'b0);
    chk("fill_ovf", OVF, 1);

    // Drain 17 times; 17th sets UDF and RD_DATA holds 15.
    for (int i = 0; i < 17; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("drain_hold", RD_DATA, 15);
    chk("drain_udf", UDF, 1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // Preload 3 and stream 40 cycles through the pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 7), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 4'((i * 5 + 3) % 16), 1'b1, 1'b0);
    chk("stream_count", COUNT, 3);

    // Fill to FULL, then simultaneous read/write at FULL.
    for (int i = 0; i < 13; i++) step(1'b1, 4'(15 - i), 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b1, 1'b0);
    chk("full_both_count", COUNT, 15);
    chk("full_both_ovf", OVF, 1);

    // Drain to EMPTY, then simultaneous read/write at EMPTY.
    for (int i = 0; i < 15; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'h6, 1'b1, 1'b0);
    chk("empty_both_count", COUNT, 1);
    chk("empty_both_udf", UDF, 1);
    chk("empty_both_vld", RD_VALID, 0);

    // Reach COUNT 9 and FLUSH with both requests high.
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i + 2), 1'b0, 1'b0);
    chk("pre_flush_count", COUNT, 9);
    step(1'b1, 4'h5, 1'b1, 1'b1);
    chk("flush_count", COUNT, 0);
    chk("flush_flags", {OVF, UDF, RD_VALID, EMPTY}, 4'b0001);

    // Async reset dropped between edges while streaming.
    step(1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 3), 1'b1, 1'b0);
    #1;
    RSTN = 1'b0;
    #1;
    reset_vals("arst");
    model_reset();
    @(posedge CLK); #1;
    RSTN = 1'b1;
    step(1'b1, 4'hC, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("post_rst_data", RD_DATA, 4'hC);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
